mem_port_arbiter: RTL and testbench

Shares one external memory port between the `mem_read` and `mem_write` dataflow processes of `mem_hw`. It accepts burst requests from both processes and grants the port to one of them per burst, alternating when both request. It forwards the command and then streams the data beats between the owning process and memory. It is the single owner of the memory command channel, so the two processes never contend at the port.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_watchdog.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding, owner
// constants and the latched memory command.
package mem_arb_pkg;

   localparam int ARB_ADDR_W  = 32;
   localparam int ARB_BURST_W = 8;

   localparam logic OWN_RD = 1'b0;
   localparam logic OWN_WR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CMD      = 2'd1,
      ST_RD_BEATS = 2'd2,
      ST_WR_BEATS = 2'd3
   } arb_state_e;

   typedef struct packed {
      logic                   we;
      logic [ARB_ADDR_W-1:0]  addr;
      logic [ARB_BURST_W-1:0] len;
   } mem_cmd_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Stall watchdog for the memory port arbiter: counts cycles without progress
// while busy and raises a sticky flag at WDOG_CYCLES (used under MEM_ARB_WATCHDOG_EN).
module mem_arb_watchdog #(
   parameter int WDOG_CYCLES = 1024
) (
   input  logic clock,
   input  logic reset,
   input  logic active,
   input  logic progress,
   output logic stall_err
);

   localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

   logic [CNT_W-1:0] cnt_r;
   logic             stall_r;

   // Saturating stall counter plus sticky flag; the flag rises on the edge the count reaches the threshold
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_r   <= '0;
         stall_r <= 1'b0;
      end else begin
         if (!active || progress) begin
            cnt_r <= '0;
         end else if (cnt_r != CNT_W'(WDOG_CYCLES)) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end else begin
            cnt_r <= cnt_r;
         end
         if (active && !progress && (cnt_r == CNT_W'(WDOG_CYCLES - 1))) begin
            stall_r <= 1'b1;
         end else begin
            stall_r <= stall_r;
         end
      end
   end

   assign stall_err = stall_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between the mem_read and mem_write processes,
// one burst at a time. Optional stall watchdog: define MEM_ARB_WATCHDOG_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = ARB_ADDR_W,
   parameter int DATA_W      = 64,
   parameter int BURST_W     = ARB_BURST_W,
   parameter int WDOG_CYCLES = 1024
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               rd_req_vld,
   output logic               rd_req_rdy,
   input  logic [ADDR_W-1:0]  rd_req_addr,
   input  logic [BURST_W-1:0] rd_req_len,
   output logic               rd_data_vld,
   input  logic               rd_data_rdy,
   output logic [DATA_W-1:0]  rd_data,
   output logic               rd_data_last,
   input  logic               wr_req_vld,
   output logic               wr_req_rdy,
   input  logic [ADDR_W-1:0]  wr_req_addr,
   input  logic [BURST_W-1:0] wr_req_len,
   input  logic               wr_data_vld,
   output logic               wr_data_rdy,
   input  logic [DATA_W-1:0]  wr_data,
   output logic               mem_cmd_vld,
   input  logic               mem_cmd_rdy,
   output logic               mem_cmd_we,
   output logic [ADDR_W-1:0]  mem_cmd_addr,
   output logic [BURST_W-1:0] mem_cmd_len,
   output logic               mem_wdata_vld,
   input  logic               mem_wdata_rdy,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic               mem_rdata_vld,
   output logic               mem_rdata_rdy,
   input  logic [DATA_W-1:0]  mem_rdata,
   output logic               busy,
   output logic               owner,
   output logic               stall_err
);

   arb_state_e         state_r;
   mem_cmd_t           cmd_r;
   logic [BURST_W-1:0] beat_cnt_r;
   logic               last_owner_r;

   logic grant_rd_s;
   logic grant_wr_s;
   logic beat_hs_s;
   logic last_beat_s;
   logic busy_s;
   logic stall_err_s;

   // Grant: sole requester wins; on a tie the side that did not own last
   always_comb begin
      grant_rd_s = 1'b0;
      grant_wr_s = 1'b0;
      if (rd_req_vld && wr_req_vld) begin
         grant_rd_s = (last_owner_r == OWN_WR);
         grant_wr_s = (last_owner_r == OWN_RD);
      end else begin
         grant_rd_s = rd_req_vld;
         grant_wr_s = wr_req_vld;
      end
   end

   // Handshake gating: every valid/ready is zero unless its state owns it
   always_comb begin
      rd_req_rdy    = 1'b0;
      wr_req_rdy    = 1'b0;
      mem_cmd_vld   = 1'b0;
      rd_data_vld   = 1'b0;
      mem_rdata_rdy = 1'b0;
      rd_data_last  = 1'b0;
      mem_wdata_vld = 1'b0;
      wr_data_rdy   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            rd_req_rdy = grant_rd_s;
            wr_req_rdy = grant_wr_s;
         end
         ST_CMD: begin
            mem_cmd_vld = 1'b1;
         end
         ST_RD_BEATS: begin
            rd_data_vld   = mem_rdata_vld;
            mem_rdata_rdy = rd_data_rdy;
            rd_data_last  = last_beat_s;
         end
         ST_WR_BEATS: begin
            mem_wdata_vld = wr_data_vld;
            wr_data_rdy   = mem_wdata_rdy;
         end
         default: begin
            mem_cmd_vld = 1'b0;
         end
      endcase
   end

   assign beat_hs_s   = ((state_r == ST_RD_BEATS) && mem_rdata_vld && rd_data_rdy) ||
                        ((state_r == ST_WR_BEATS) && wr_data_vld && mem_wdata_rdy);
   assign last_beat_s = (beat_cnt_r == cmd_r.len);
   assign busy_s      = (state_r != ST_IDLE);

   // Burst FSM; the counter is never incremented on the last beat, so it cannot wrap
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         cmd_r        <= '0;
         beat_cnt_r   <= '0;
         last_owner_r <= OWN_WR;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (rd_req_vld && rd_req_rdy) begin
                  cmd_r        <= '{we: 1'b0, addr: rd_req_addr, len: rd_req_len};
                  last_owner_r <= OWN_RD;
                  state_r      <= ST_CMD;
               end else if (wr_req_vld && wr_req_rdy) begin
                  cmd_r        <= '{we: 1'b1, addr: wr_req_addr, len: wr_req_len};
                  last_owner_r <= OWN_WR;
                  state_r      <= ST_CMD;
               end
            end
            ST_CMD: begin
               if (mem_cmd_rdy) begin
                  beat_cnt_r <= '0;
                  state_r    <= cmd_r.we ? ST_WR_BEATS : ST_RD_BEATS;
               end
            end
            ST_RD_BEATS, ST_WR_BEATS: begin
               if (beat_hs_s) begin
                  if (last_beat_s) begin
                     state_r <= ST_IDLE;
                  end else begin
                     beat_cnt_r <= beat_cnt_r + BURST_W'(1);
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign rd_data      = mem_rdata;
   assign mem_wdata    = wr_data;
   assign mem_cmd_we   = cmd_r.we;
   assign mem_cmd_addr = cmd_r.addr;
   assign mem_cmd_len  = cmd_r.len;
   assign busy         = busy_s;
   assign owner        = last_owner_r;
   assign stall_err    = stall_err_s;

`ifdef MEM_ARB_WATCHDOG_EN
   logic progress_s;
   assign progress_s = (mem_cmd_vld && mem_cmd_rdy) || beat_hs_s;

   mem_arb_watchdog #(
      .WDOG_CYCLES (WDOG_CYCLES)
   ) u_watchdog (
      .clock     (clock),
      .reset     (reset),
      .active    (busy_s),
      .progress  (progress_s),
      .stall_err (stall_err_s)
   );
`else
   assign stall_err_s = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: arbitration, passthrough,
// backpressure, burst-length boundaries, watchdog flag and mid-burst reset.
module tb_mem_port_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        rd_req_vld, rd_req_rdy;
   logic [31:0] rd_req_addr;
   logic [7:0]  rd_req_len;
   logic        rd_data_vld, rd_data_rdy;
   logic [63:0] rd_data;
   logic        rd_data_last;
   logic        wr_req_vld, wr_req_rdy;
   logic [31:0] wr_req_addr;
   logic [7:0]  wr_req_len;
   logic        wr_data_vld, wr_data_rdy;
   logic [63:0] wr_data;
   logic        mem_cmd_vld, mem_cmd_rdy, mem_cmd_we;
   logic [31:0] mem_cmd_addr;
   logic [7:0]  mem_cmd_len;
   logic        mem_wdata_vld, mem_wdata_rdy;
   logic [63:0] mem_wdata;
   logic        mem_rdata_vld, mem_rdata_rdy;
   logic [63:0] mem_rdata;
   logic        busy, owner, stall_err;

   int n_pass  = 0;
   int n_total = 0;

`ifdef MEM_ARB_WATCHDOG_EN
   localparam logic WD_ON = 1'b1;
`else
   localparam logic WD_ON = 1'b0;
`endif

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .BURST_W(8), .WDOG_CYCLES(16)) dut (
      .clock(clock), .reset(reset),
      .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy), .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
      .rd_data_vld(rd_data_vld), .rd_data_rdy(rd_data_rdy), .rd_data(rd_data), .rd_data_last(rd_data_last),
      .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy), .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
      .wr_data_vld(wr_data_vld), .wr_data_rdy(wr_data_rdy), .wr_data(wr_data),
      .mem_cmd_vld(mem_cmd_vld), .mem_cmd_rdy(mem_cmd_rdy), .mem_cmd_we(mem_cmd_we),
      .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
      .mem_wdata_vld(mem_wdata_vld), .mem_wdata_rdy(mem_wdata_rdy), .mem_wdata(mem_wdata),
      .mem_rdata_vld(mem_rdata_vld), .mem_rdata_rdy(mem_rdata_rdy), .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner), .stall_err(stall_err)
   );

   always #5 clock = ~clock;

   // Stimulus helpers: they only drive and observe; every test task judges the results itself
   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic accept_cmd(output logic we, output logic [31:0] addr, output logic [7:0] len, output int waited);
      waited = 0;
      while (mem_cmd_vld !== 1'b1 && waited < 20) begin
         next_cycle();
         waited++;
      end
      we = mem_cmd_we; addr = mem_cmd_addr; len = mem_cmd_len;
      mem_cmd_rdy = 1'b1;
      next_cycle();
      mem_cmd_rdy = 1'b0;
   endtask

   task automatic read_beats(input int n, input logic [63:0] base, output int good, output int last_ok);
      good = 0; last_ok = 0;
      for (int i = 0; i < n; i++) begin
         mem_rdata = base + 64'(i); mem_rdata_vld = 1'b1; rd_data_rdy = 1'b1;
         #1;
         if (rd_data_vld === 1'b1 && mem_rdata_rdy === 1'b1 && rd_data === base + 64'(i)) good++;
         if (rd_data_last === ((i == n - 1) ? 1'b1 : 1'b0)) last_ok++;
         next_cycle();
      end
      mem_rdata_vld = 1'b0; rd_data_rdy = 1'b0;
   endtask

   task automatic write_beats(input int n, input logic [63:0] base, output int good);
      good = 0;
      for (int i = 0; i < n; i++) begin
         wr_data = base + 64'(i); wr_data_vld = 1'b1; mem_wdata_rdy = 1'b1;
         #1;
         if (mem_wdata_vld === 1'b1 && wr_data_rdy === 1'b1 && mem_wdata === base + 64'(i)) good++;
         next_cycle();
      end
      wr_data_vld = 1'b0; mem_wdata_rdy = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      mem_rdata_vld = 1'b1; wr_data_vld = 1'b1; rd_data_rdy = 1'b1; mem_wdata_rdy = 1'b1;
      repeat (2) next_cycle();
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
      n_total++; if (owner !== 1'b1) $display("FAIL reset_owner: got %0b want 1", owner); else n_pass++;
      n_total++; if (mem_cmd_vld !== 1'b0 || mem_cmd_addr !== 32'h0 || mem_cmd_len !== 8'h0 || mem_cmd_we !== 1'b0)
         $display("FAIL reset_cmd: got vld=%0b we=%0b addr=%h len=%h want all 0", mem_cmd_vld, mem_cmd_we, mem_cmd_addr, mem_cmd_len);
      else n_pass++;
      n_total++; if (rd_data_vld !== 1'b0 || mem_rdata_rdy !== 1'b0 || mem_wdata_vld !== 1'b0 || wr_data_rdy !== 1'b0)
         $display("FAIL reset_gating: got %b want 0000", {rd_data_vld, mem_rdata_rdy, mem_wdata_vld, wr_data_rdy});
      else n_pass++;
      n_total++; if (stall_err !== 1'b0) $display("FAIL reset_stall_err: got %0b want 0", stall_err); else n_pass++;
      mem_rdata_vld = 1'b0; wr_data_vld = 1'b0; rd_data_rdy = 1'b0; mem_wdata_rdy = 1'b0;
      reset = 1'b1;
      next_cycle();
   endtask

   task automatic test_tie_alternation();
      logic we; logic [31:0] addr; logic [7:0] len; int waited, good, last_ok;
      rd_req_vld = 1'b1; rd_req_addr = 32'h10; rd_req_len = 8'd0;
      wr_req_vld = 1'b1; wr_req_addr = 32'h20; wr_req_len = 8'd0;
      #1;
      n_total++; if ({rd_req_rdy, wr_req_rdy} !== 2'b10) $display("FAIL tie1_grant: got rd/wr rdy=%b want 10", {rd_req_rdy, wr_req_rdy}); else n_pass++;
      next_cycle();
      rd_req_vld = 1'b0;
      n_total++; if (wr_req_rdy !== 1'b0 || owner !== 1'b0) $display("FAIL tie1_busy: got wr_rdy=%0b owner=%0b want 0 0", wr_req_rdy, owner); else n_pass++;
      accept_cmd(we, addr, len, waited);
      n_total++; if (we !== 1'b0 || addr !== 32'h10) $display("FAIL tie1_cmd: got we=%0b addr=%h want 0 00000010", we, addr); else n_pass++;
      read_beats(1, 64'h1111_0000, good, last_ok);
      rd_req_vld = 1'b1;
      #1;
      n_total++; if ({rd_req_rdy, wr_req_rdy} !== 2'b01) $display("FAIL tie2_grant: got rd/wr rdy=%b want 01", {rd_req_rdy, wr_req_rdy}); else n_pass++;
      next_cycle();
      wr_req_vld = 1'b0;
      accept_cmd(we, addr, len, waited);
      n_total++; if (we !== 1'b1 || addr !== 32'h20 || owner !== 1'b1) $display("FAIL tie2_cmd: got we=%0b addr=%h owner=%0b want 1 00000020 1", we, addr, owner); else n_pass++;
      write_beats(1, 64'h2222_0000, good);
      n_total++; if (good !== 1) $display("FAIL tie2_beats: got %0d want 1", good); else n_pass++;
      wr_req_vld = 1'b1;
      #1;
      n_total++; if ({rd_req_rdy, wr_req_rdy} !== 2'b10) $display("FAIL tie3_grant: got rd/wr rdy=%b want 10", {rd_req_rdy, wr_req_rdy}); else n_pass++;
      next_cycle();
      rd_req_vld = 1'b0; wr_req_vld = 1'b0;
      accept_cmd(we, addr, len, waited);
      read_beats(1, 64'h3333_0000, good, last_ok);
      n_total++; if (good !== 1 || busy !== 1'b0) $display("FAIL tie3_done: got beats=%0d busy=%0b want 1 0", good, busy); else n_pass++;
   endtask

   task automatic test_read_burst();
      logic we; logic [31:0] addr; logic [7:0] len; int waited, good, last_ok;
      rd_req_vld = 1'b1; rd_req_addr = 32'h100; rd_req_len = 8'd3;
      #1;
      n_total++; if (rd_req_rdy !== 1'b1) $display("FAIL rd_req_rdy: got %0b want 1", rd_req_rdy); else n_pass++;
      next_cycle();
      rd_req_vld = 1'b0;
      accept_cmd(we, addr, len, waited);
      n_total++; if (waited !== 0) $display("FAIL rd_cmd_latency: got %0d extra cycles want 0", waited); else n_pass++;
      n_total++; if ({we, addr, len} !== {1'b0, 32'h100, 8'd3}) $display("FAIL rd_cmd_fields: got we=%0b addr=%h len=%0d want 0 00000100 3", we, addr, len); else n_pass++;
      read_beats(4, 64'hDEAD_0000, good, last_ok);
      n_total++; if (good !== 4) $display("FAIL rd_beats: got %0d good beats want 4", good); else n_pass++;
      n_total++; if (last_ok !== 4) $display("FAIL rd_last: got %0d correct last flags want 4", last_ok); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL rd_idle_after: got busy=%0b want 0", busy); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic we; logic [31:0] addr; logic [7:0] len; int waited, stable, gated, sent, cyc, mirror_ok;
      logic rdy_t;
      logic [63:0] cap[$];
      wr_req_vld = 1'b1; wr_req_addr = 32'h2000; wr_req_len = 8'd3;
      next_cycle();
      wr_req_vld = 1'b0;
      wr_data_vld = 1'b1; mem_wdata_rdy = 1'b1; wr_data = 64'hBAD0;
      stable = 0; gated = 0;
      for (int i = 0; i < 5; i++) begin
         if (mem_cmd_vld === 1'b1 && mem_cmd_we === 1'b1 && mem_cmd_addr === 32'h2000 && mem_cmd_len === 8'd3) stable++;
         if (wr_data_rdy === 1'b0 && mem_wdata_vld === 1'b0) gated++;
         next_cycle();
      end
      n_total++; if (stable !== 5) $display("FAIL bp_cmd_stable: got %0d stable cycles want 5", stable); else n_pass++;
      n_total++; if (gated !== 5) $display("FAIL bp_cmd_gating: got %0d gated cycles want 5", gated); else n_pass++;
      wr_data_vld = 1'b0; mem_wdata_rdy = 1'b0;
      accept_cmd(we, addr, len, waited);
      sent = 0; cyc = 0; mirror_ok = 0;
      while (sent < 4 && cyc < 20) begin
         rdy_t = (cyc % 2 == 1) ? 1'b1 : 1'b0;
         wr_data = 64'hBEEF_0000 + 64'(sent); wr_data_vld = 1'b1; mem_wdata_rdy = rdy_t;
         #1;
         if (wr_data_rdy === rdy_t && mem_wdata_vld === 1'b1) mirror_ok++;
         if (rdy_t) begin cap.push_back(mem_wdata); sent++; end
         cyc++;
         next_cycle();
      end
      wr_data_vld = 1'b0; mem_wdata_rdy = 1'b0;
      n_total++; if (mirror_ok !== 8 || cyc !== 8) $display("FAIL bp_mirror: got %0d/%0d mirrored cycles want 8/8", mirror_ok, cyc); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (i >= cap.size() || cap[i] !== 64'hBEEF_0000 + 64'(i)) $display("FAIL bp_beat%0d: got %h want %h", i, (i < cap.size()) ? cap[i] : 64'hX, 64'hBEEF_0000 + 64'(i));
         else n_pass++;
      end
      n_total++; if (busy !== 1'b0) $display("FAIL bp_idle_after: got busy=%0b want 0", busy); else n_pass++;
   endtask

   task automatic test_boundaries();
      logic we; logic [31:0] addr; logic [7:0] len; int waited, good, last_ok;
      rd_req_vld = 1'b1; rd_req_addr = 32'h0; rd_req_len = 8'd0;
      next_cycle();
      rd_req_vld = 1'b0;
      accept_cmd(we, addr, len, waited);
      read_beats(1, 64'h0, good, last_ok);
      n_total++; if (good !== 1 || last_ok !== 1 || busy !== 1'b0) $display("FAIL len0: got beats=%0d last=%0d busy=%0b want 1 1 0", good, last_ok, busy); else n_pass++;
      rd_req_vld = 1'b1; rd_req_addr = 32'h4000; rd_req_len = 8'd255;
      next_cycle();
      rd_req_vld = 1'b0;
      accept_cmd(we, addr, len, waited);
      n_total++; if (len !== 8'd255) $display("FAIL len255_cmd: got len=%0d want 255", len); else n_pass++;
      read_beats(256, 64'h5000_0000, good, last_ok);
      n_total++; if (good !== 256 || last_ok !== 256) $display("FAIL len255_beats: got beats=%0d last=%0d want 256 256", good, last_ok); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL len255_idle: got busy=%0b want 0", busy); else n_pass++;
   endtask

   task automatic test_watchdog();
      logic we; logic [31:0] addr; logic [7:0] len; int waited, good, last_ok;
      rd_req_vld = 1'b1; rd_req_addr = 32'h600; rd_req_len = 8'd0;
      next_cycle();
      rd_req_vld = 1'b0;
      repeat (15) next_cycle();
      n_total++; if (stall_err !== 1'b0) $display("FAIL wdog_15: got %0b want 0", stall_err); else n_pass++;
      next_cycle();
      n_total++; if (stall_err !== WD_ON) $display("FAIL wdog_16: got %0b want %0b", stall_err, WD_ON); else n_pass++;
      repeat (4) next_cycle();
      accept_cmd(we, addr, len, waited);
      read_beats(1, 64'h6, good, last_ok);
      n_total++; if (stall_err !== WD_ON || busy !== 1'b0) $display("FAIL wdog_sticky: got err=%0b busy=%0b want %0b 0", stall_err, busy, WD_ON); else n_pass++;
   endtask

   task automatic test_reset_mid_burst();
      logic we; logic [31:0] addr; logic [7:0] len; int waited, good, last_ok;
      rd_req_vld = 1'b1; rd_req_addr = 32'h300; rd_req_len = 8'd7;
      next_cycle();
      rd_req_vld = 1'b0;
      accept_cmd(we, addr, len, waited);
      read_beats(2, 64'h7000, good, last_ok);
      n_total++; if (good !== 2) $display("FAIL mid_pre_beats: got %0d want 2", good); else n_pass++;
      mem_rdata_vld = 1'b1; rd_data_rdy = 1'b1;
      #1;
      reset = 1'b0;
      #1;
      n_total++; if ({rd_data_vld, mem_rdata_rdy, rd_data_last, busy} !== 4'b0000) $display("FAIL mid_reset_gating: got %b want 0000", {rd_data_vld, mem_rdata_rdy, rd_data_last, busy}); else n_pass++;
      n_total++; if (owner !== 1'b1 || stall_err !== 1'b0 || mem_cmd_addr !== 32'h0 || mem_cmd_len !== 8'h0)
         $display("FAIL mid_reset_regs: got owner=%0b err=%0b addr=%h len=%h want 1 0 0 0", owner, stall_err, mem_cmd_addr, mem_cmd_len);
      else n_pass++;
      mem_rdata_vld = 1'b0; rd_data_rdy = 1'b0;
      next_cycle();
      reset = 1'b1;
      next_cycle();
      wr_req_vld = 1'b1; wr_req_addr = 32'h500; wr_req_len = 8'd1;
      #1;
      n_total++; if ({rd_req_rdy, wr_req_rdy} !== 2'b01) $display("FAIL post_reset_grant: got rd/wr rdy=%b want 01", {rd_req_rdy, wr_req_rdy}); else n_pass++;
      next_cycle();
      wr_req_vld = 1'b0;
      accept_cmd(we, addr, len, waited);
      n_total++; if ({we, addr, len} !== {1'b1, 32'h500, 8'd1}) $display("FAIL post_reset_cmd: got we=%0b addr=%h len=%0d want 1 00000500 1", we, addr, len); else n_pass++;
      write_beats(2, 64'h8000, good);
      n_total++; if (good !== 2 || busy !== 1'b0 || owner !== 1'b1) $display("FAIL post_reset_burst: got beats=%0d busy=%0b owner=%0b want 2 0 1", good, busy, owner); else n_pass++;
   endtask

   initial begin
      reset = 1'b0;
      rd_req_vld = 1'b0; rd_req_addr = 32'h0; rd_req_len = 8'h0; rd_data_rdy = 1'b0;
      wr_req_vld = 1'b0; wr_req_addr = 32'h0; wr_req_len = 8'h0;
      wr_data_vld = 1'b0; wr_data = 64'h0;
      mem_cmd_rdy = 1'b0; mem_wdata_rdy = 1'b0; mem_rdata_vld = 1'b0; mem_rdata = 64'h0;
      #1;
      test_reset();
      test_tie_alternation();
      test_read_burst();
      test_backpressure();
      test_boundaries();
      test_watchdog();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
